// File: rtl/pll_seq_pkg.sv
// Shared types and widths for the PLL power-up / relock reset sequencer.
package pll_seq_pkg;

   localparam int unsigned TIMER_W = 32;
   localparam int unsigned RETRY_W = 4;

   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      FAIL      = 3'd4
   } seq_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous status bit; resets to 0.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences PLL areset / lock qualification and holds the downstream system
// reset until the PLL is usable; bounded retries, then parks in FAIL.
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter logic [31:0] AREST_CYC        = 32'd16,
   parameter logic [31:0] LOCK_TIMEOUT_CYC = 32'd50000,
   parameter logic [31:0] LOCK_STABLE_CYC  = 32'd1024,
   parameter logic [3:0]  MAX_RETRY        = 4'd3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               locked,
   input  logic               restart,
   output logic               pll_areset,
   output logic               sys_rst_n,
   output logic               ready,
   output logic               fail,
   output logic               lock_lost,
   output logic [RETRY_W-1:0] retry_cnt,
   output logic [2:0]         state
);

   logic               locked_s;
   seq_state_t         state_q;
   seq_state_t         state_d;
   logic [TIMER_W-1:0] timer;
   logic [TIMER_W-1:0] timer_d;
   logic [RETRY_W-1:0] retry_d;
   logic               lost_d;
   logic               attempt_fail;

   sync_2ff u_lock_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (locked),
      .q     (locked_s)
   );

   always_comb begin
      state_d      = state_q;
      retry_d      = retry_cnt;
      lost_d       = 1'b0;
      attempt_fail = 1'b0;

      if (restart) begin
         state_d = RESET_PLL;
         retry_d = '0;
      end else begin
         case (state_q)
            RESET_PLL: if (timer == AREST_CYC - 32'd1) state_d = WAIT_LOCK;
            WAIT_LOCK: begin
               if (locked_s)
                  state_d = (LOCK_STABLE_CYC <= 32'd1) ? RUN : STABLE;
               else if (timer == LOCK_TIMEOUT_CYC - 32'd1)
                  attempt_fail = 1'b1;
            end
            STABLE: begin
               if (!locked_s)
                  attempt_fail = 1'b1;
               else if (timer == LOCK_STABLE_CYC - 32'd1)
                  state_d = RUN;
            end
            RUN: begin
               if (!locked_s) begin
                  lost_d  = 1'b1;
                  retry_d = '0;
                  state_d = RESET_PLL;
               end
            end
            FAIL:    state_d = FAIL;
            default: state_d = RESET_PLL;
         endcase

         if (attempt_fail) begin
            if (retry_cnt < MAX_RETRY) begin
               retry_d = retry_cnt + 4'd1;
               state_d = RESET_PLL;
            end else begin
               state_d = FAIL;
            end
         end
      end

      // The WAIT_LOCK cycle that saw lock already counts as the first stable
      // cycle, so STABLE starts its count at 1.
      if (restart || (state_d != state_q))
         timer_d = (state_d == STABLE) ? 32'd1 : '0;
      else if ((state_q == RESET_PLL) || (state_q == WAIT_LOCK) || (state_q == STABLE))
         timer_d = timer + 32'd1;
      else
         timer_d = timer;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RESET_PLL;
         timer      <= '0;
         retry_cnt  <= '0;
         pll_areset <= 1'b1;
         sys_rst_n  <= 1'b0;
         ready      <= 1'b0;
         fail       <= 1'b0;
         lock_lost  <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer      <= timer_d;
         retry_cnt  <= retry_d;
         pll_areset <= (state_d == RESET_PLL) || (state_d == FAIL);
         sys_rst_n  <= (state_d == RUN);
         ready      <= (state_d == RUN);
         fail       <= (state_d == FAIL);
         lock_lost  <= lost_d;
      end
   end

   assign state = state_q;

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Controller that sequences the on-chip PLL at power-up and after loss of lock.
- Holds the PLL `areset` for a fixed time, waits for `locked` with a timeout, and qualifies lock as stable.
- Releases a downstream active-low system reset only once the PLL is usable.
- Retries a bounded number of times, then parks in a fail state.
- Sits between the board clock/reset pins and the PLL instance; its `sys_rst_n` gates every block clocked from PLL outputs (e.g. LED blink counters).

## Interface
- `AREST_CYC`, 32'd16 – cycles `pll_areset` is held high per attempt (≥1).
- `LOCK_TIMEOUT_CYC`, 32'd50000 – cycles allowed in WAIT_LOCK before the attempt fails (≥1).
- `LOCK_STABLE_CYC`, 32'd1024 – consecutive synchronized-lock cycles required before RUN (≥1).
- `MAX_RETRY`, 4'd3 – failed attempts allowed beyond the first before FAIL (0..15).
- `clk` in 1 – board clock (50 MHz), same clock that feeds PLL `inclk0`.
- `rst_n` in 1 – asynchronous, active-low reset.
- `locked` in 1 – PLL lock status, asynchronous to `clk`.
- `restart` in 1 – synchronous single-cycle request to re-run the whole sequence.
- `pll_areset` out 1 – PLL reset, active high.
- `sys_rst_n` out 1 – downstream reset, active low.
- `ready` out 1 – high only in RUN.
- `fail` out 1 – high only in FAIL.
- `lock_lost` out 1 – one-cycle pulse on lock drop while in RUN.
- `retry_cnt` out 4 – failed attempts in the current sequence.
- `state` out 3 – current FSM state, for debug.

## Operation
- `locked` passes through a 2-FF synchronizer, producing `locked_s`. The FSM never samples raw `locked`.
- One 32-bit state timer. It clears on every state entry. A state of length N exits when timer == N-1, so it is occupied exactly N cycles.
- States and outputs:
  - RESET_PLL: `pll_areset`=1.
  - WAIT_LOCK: `pll_areset`=0.
  - STABLE: `pll_areset`=0.
  - RUN: `sys_rst_n`=1, `ready`=1.
  - FAIL: `pll_areset`=1, `fail`=1.
  - `sys_rst_n`=0 in every state except RUN.
- Transitions:
  - RESET_PLL → WAIT_LOCK after AREST_CYC cycles.
  - WAIT_LOCK → STABLE when `locked_s`=1.
  - WAIT_LOCK timeout (timer == LOCK_TIMEOUT_CYC-1 with `locked_s`=0): if `retry_cnt` < MAX_RETRY, increment it and go to RESET_PLL; otherwise go to FAIL.
  - STABLE → RUN after LOCK_STABLE_CYC consecutive cycles of `locked_s`=1.
  - Any `locked_s`=0 in STABLE counts as a failed attempt and follows the same retry/FAIL rule as a timeout.
  - RUN: `locked_s`=0 pulses `lock_lost`, clears `retry_cnt`, and goes to RESET_PLL.
  - FAIL is left only by `restart` or `rst_n`.
- `restart`=1 in any state clears `retry_cnt` and goes to RESET_PLL. It has priority over every other transition in the same cycle.
- In the same cycle, a lock event has priority over a timeout: `locked_s`=1 on the timeout cycle goes to STABLE.

## Timing
- Reset (rst_n=0), applied asynchronously:
  - `pll_areset`=1, `sys_rst_n`=0, `ready`=0, `fail`=0, `lock_lost`=0.
  - `retry_cnt`=0, state=RESET_PLL, synchronizer flops=0.
- All outputs are registered and change on the clock edge of the state transition. No combinational paths from input to output.
- `locked` to FSM reaction: 2 cycles of synchronizer latency plus 1 cycle of registered state.
- Lock-to-`sys_rst_n` release: 2 + LOCK_STABLE_CYC cycles after `locked` rises, given no dropout.
- Loss of lock in RUN: `sys_rst_n` falls and `lock_lost` pulses 3 cycles after `locked` falls. `pll_areset` rises on the same edge.
- Reset asserted mid-sequence: the sequence aborts immediately and all state returns to reset values. Deassertion restarts from RESET_PLL with a full AREST_CYC.

## Structure
- Package `pll_seq_pkg`:
  - state enum: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4;
  - timer width constant (32);
  - `retry_cnt` width constant (4).
- Sub-module `sync_2ff` (1-bit, async active-low reset to 0) for `locked`, reusable for other async status inputs.
- FSM and timer live in `pll_reset_sequencer`.

## Test plan
Parameters for all scenarios: AREST_CYC=4, LOCK_TIMEOUT_CYC=20, LOCK_STABLE_CYC=8, MAX_RETRY=2.
- Nominal: release rst_n, raise `locked` 10 cycles later and hold → `pll_areset` high exactly 4 cycles; `sys_rst_n` and `ready` rise 10 cycles after `locked` rises; `retry_cnt`=0.
- Chatter: `locked` high 5 cycles then low 1, during STABLE → `retry_cnt`=1, new 4-cycle `pll_areset` pulse, no `ready`.
- Never locks: hold `locked`=0 → three 4-cycle `pll_areset` pulses separated by 20-cycle waits, then `fail`=1, `pll_areset`=1, `retry_cnt`=2; the state holds for 1000 cycles.
- Loss in RUN: drop `locked` → `lock_lost` single pulse and `sys_rst_n`=0 3 cycles later; `retry_cnt`=0; a relock reaches RUN again.
- Restart: pulse `restart` in FAIL and in RUN → RESET_PLL next cycle, `retry_cnt`=0, `fail`=0.
- Async reset mid-STABLE: assert rst_n between clock edges → all outputs take reset values before the next edge.
